// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - shared AHB-Lite codes, SRAM slave FSM states and lane-enable helper
// Purpose: constants and types shared by the AHB-Lite SRAM slave and its sub-modules.
// Ports: none (package).
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

  // Little-endian byte-lane enables for an access of the given size.
  // Illegal sizes enable nothing.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr;
      HSIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: mask = 4'b1111;
      default:    mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// rtl/ahb_lite_sram_slave_if.sv - AHB-Lite slave-side bus bundle
// Purpose: groups the AHB-Lite signals seen by one slave.
// Ports (modport slave): in HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY;
//                        out HREADYOUT, HRESP, HRDATA. Modport master is the mirror.
interface ahb_lite_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
    input  HREADY, HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_sram_array.sv
// rtl/ahb_lite_sram_array.sv - DEPTH x 32 SRAM with byte write enables and write-to-read forwarding
// Purpose: word memory, synchronous read into a resettable output register.
// Ports: HCLK, HRESETn (async, active-low, clears rdata only);
//        we/waddr/wbe/wdata write port; re/raddr read port; rdata registered read data.
module ahb_lite_sram_array #(
  parameter int DEPTH = 256
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [3:0]               wbe,
  input  logic [31:0]              wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;

  // Memory contents survive reset on purpose.
  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // A read issued on the edge that commits a write to the same word sees
  // the new lanes merged over the old contents.
  always_comb begin
    rd_word = mem[raddr];
    if (we && (waddr == raddr)) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) rd_word[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rdata <= '0;
    else if (re)  rdata <= rd_word;
  end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite SRAM slave with wait states and two-cycle ERROR
// Purpose: captures address phases, checks legality, sequences OKAY/ERROR data
//          phases and drives the SRAM array.
// Ports: HCLK clock; HRESETn async active-low reset;
//        bus (ahb_lite_sram_slave_if.slave) AHB-Lite slave signals.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_lite_sram_slave_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  // The counter is loaded with WAIT_STATES-1 so WAIT lasts exactly WAIT_STATES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  sram_state_e state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;

  logic [AW+1:0] dp_addr_q;
  logic          dp_write_q;
  logic [2:0]    dp_size_q;
  logic          dp_legal_q;

  logic        accept;
  logic        capture;
  logic        addr_legal;
  logic        mem_we;
  logic        mem_re;
  logic [AW-1:0] mem_raddr;
  logic [31:0] hrdata;

  // Only the cycles in which this slave reports ready can end a data phase,
  // so a stray HREADY during WAIT/ERR1 cannot overwrite the pending transfer.
  assign accept  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
  assign capture = accept && bus.HSEL && bus.HREADY &&
                   ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));

  always_comb begin
    addr_legal = 1'b1;
    if (bus.HSIZE > HSIZE_WORD) addr_legal = 1'b0;
    if ((bus.HSIZE == HSIZE_HALF) && bus.HADDR[0]) addr_legal = 1'b0;
    if ((bus.HSIZE == HSIZE_WORD) && (bus.HADDR[1:0] != 2'b00)) addr_legal = 1'b0;
    if ({2'b00, bus.HADDR[31:2]} >= 32'(DEPTH)) addr_legal = 1'b0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      dp_addr_q  <= '0;
      dp_write_q <= 1'b0;
      dp_size_q  <= '0;
      dp_legal_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (capture) begin
        dp_addr_q  <= bus.HADDR[AW+1:0];
        dp_write_q <= bus.HWRITE;
        dp_size_q  <= bus.HSIZE;
        dp_legal_q <= addr_legal;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = ST_DONE;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DONE and ERR2 all end a data phase and may start the next one.
        state_d = ST_IDLE;
        if (capture) begin
          if (!addr_legal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = HRESP_OKAY;
    case (state_q)
      ST_WAIT: bus.HREADYOUT = 1'b0;
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = HRESP_ERROR;
      end
      ST_ERR2: bus.HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  // Read data is loaded on the edge entering DONE. With zero wait states that
  // edge is the capture edge itself, so the address comes straight off the bus.
  assign mem_raddr = capture ? bus.HADDR[AW+1:2] : dp_addr_q[AW+1:2];
  assign mem_re    = (state_d == ST_DONE) && (capture ? !bus.HWRITE : !dp_write_q);
  assign mem_we    = (state_q == ST_DONE) && dp_write_q && dp_legal_q;

  ahb_lite_sram_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .we      (mem_we),
    .waddr   (dp_addr_q[AW+1:2]),
    .wbe     (lane_mask(dp_size_q, dp_addr_q[1:0])),
    .wdata   (bus.HWDATA),
    .re      (mem_re),
    .raddr   (mem_raddr),
    .rdata   (hrdata)
  );

  assign bus.HRDATA = hrdata;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb/tb_ahb_lite_sram_slave.sv - self-checking bench for ahb_lite_sram_slave
module tb_ahb_lite_sram_slave;
  import ahb_lite_pkg::*;

  localparam int DEPTH = 256;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } item_t;

  typedef struct {
    int          waits;
    logic [1:0]  resp;   // {OR of HRESP over stalled cycles, HRESP on final cycle}
    logic [31:0] rdata;
  } rec_t;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic        b_sel;
  logic [1:0]  b_trans;
  logic        b_write;
  logic [2:0]  b_size;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic [1:0]  cur;

  logic        rdy_v   [3];
  logic        resp_v  [3];
  logic [31:0] rdata_v [3];

  ahb_lite_sram_slave_if bus_if [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus_if[g].HSEL   = b_sel && (cur == 2'(g));
    assign bus_if[g].HADDR  = b_addr;
    assign bus_if[g].HWRITE = b_write;
    assign bus_if[g].HSIZE  = b_size;
    assign bus_if[g].HTRANS = b_trans;
    assign bus_if[g].HWDATA = b_wdata;
    assign bus_if[g].HREADY = bus_if[g].HREADYOUT;
    ahb_lite_sram_slave #(
      .DEPTH       (DEPTH),
      .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) u_dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus_if[g])
    );
    assign rdy_v[g]   = bus_if[g].HREADYOUT;
    assign resp_v[g]  = bus_if[g].HRESP;
    assign rdata_v[g] = bus_if[g].HRDATA;
  end

  logic        o_rdy, o_resp;
  logic [31:0] o_rdata;
  assign o_rdy   = rdy_v[cur];
  assign o_resp  = resp_v[cur];
  assign o_rdata = rdata_v[cur];

  item_t       xq[$];
  rec_t        sb[$];
  rec_t        obs[$];
  logic [31:0] mdl [3][DEPTH];
  logic [31:0] last_rd [3];
  int vectors = 0;
  int miscompares = 0;

  function automatic int ws_of(input logic [1:0] i);
    return (i == 2'd0) ? 0 : (i == 2'd1) ? 2 : 3;
  endfunction

  function automatic bit ref_legal(input logic [2:0] sz, input logic [31:0] a);
    if (sz > 3'd2) return 1'b0;
    if (sz == 3'd1 && a[0]) return 1'b0;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    if (a[31:2] >= DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit lane_on(input logic [2:0] sz, input logic [1:0] a, input int b);
    case (sz)
      3'd0:    return b == int'(a);
      3'd1:    return (b / 2) == int'(a[1]);
      3'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_write(input item_t x);
    for (int b = 0; b < 4; b++)
      if (lane_on(x.size, x.addr[1:0], b)) mdl[cur][x.addr[9:2]][8*b +: 8] = x.wdata[8*b +: 8];
  endtask

  task automatic add(input logic s, input logic [1:0] t, input logic w,
                     input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    item_t x;
    x.sel = s; x.trans = t; x.write = w; x.size = sz; x.addr = a; x.wdata = d;
    xq.push_back(x);
  endtask

  task automatic drive_idle();
    b_sel = 1'b0; b_trans = HTRANS_IDLE; b_write = 1'b0; b_size = HSIZE_WORD;
    b_addr = '0; b_wdata = '0;
  endtask

  // Pipelined AHB master: drives queued transfers, records expectations in sb
  // when a cycle is driven or an address phase is accepted, and records what
  // the slave returns in obs. Called at posedge+1.
  task automatic run_bus();
    item_t dp, it;
    bit    dp_v;
    int    waits, guard;
    logic  low_resp;
    rec_t  e, o;
    dp_v = 1'b0; waits = 0; low_resp = 1'b0; guard = 0;
    while ((xq.size() > 0 || dp_v) && guard < 500) begin
      guard++;
      if (xq.size() > 0) begin
        b_sel = xq[0].sel; b_trans = xq[0].trans; b_write = xq[0].write;
        b_size = xq[0].size; b_addr = xq[0].addr;
      end else begin
        b_sel = 1'b0; b_trans = HTRANS_IDLE;
      end
      b_wdata = (dp_v && dp.write) ? dp.wdata : 32'h0;
      if (!dp_v) begin
        e.waits = 0; e.resp = 2'b00; e.rdata = last_rd[cur];
        sb.push_back(e);
      end
      @(negedge HCLK);
      if (dp_v && !o_rdy) begin
        waits++;
        low_resp = low_resp | o_resp;
      end else begin
        o.waits = (!dp_v && !o_rdy) ? 1 : waits;
        o.resp  = {low_resp, o_resp};
        o.rdata = o_rdata;
        obs.push_back(o);
      end
      @(posedge HCLK);
      if (o_rdy) begin
        if (dp_v && dp.write && ref_legal(dp.size, dp.addr)) model_write(dp);
        dp_v = 1'b0;
        if (xq.size() > 0) begin
          it = xq.pop_front();
          if (it.sel && it.trans[1]) begin
            dp = it; dp_v = 1'b1; waits = 0; low_resp = 1'b0;
            if (ref_legal(it.size, it.addr)) begin
              e.waits = ws_of(cur); e.resp = 2'b00;
              if (!it.write) last_rd[cur] = mdl[cur][it.addr[9:2]];
            end else begin
              e.waits = 1; e.resp = 2'b11;
            end
            e.rdata = last_rd[cur];
            sb.push_back(e);
          end
        end
      end
      #1;
    end
    if (guard >= 500) begin
      vectors++; miscompares++;
      $display("FAIL bus_timeout pending=%0d want 0", xq.size());
      xq.delete();
    end
    drive_idle();
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    drive_idle();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rdy_v[i] !== 1'b1) begin miscompares++; $display("FAIL reset_hreadyout dut%0d got %b want 1", i, rdy_v[i]); end
      vectors++;
      if (resp_v[i] !== 1'b0) begin miscompares++; $display("FAIL reset_hresp dut%0d got %b want 0", i, resp_v[i]); end
      vectors++;
      if (rdata_v[i] !== 32'h0) begin miscompares++; $display("FAIL reset_hrdata dut%0d got %h want 0", i, rdata_v[i]); end
      last_rd[i] = 32'h0;
    end
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    cur = 2'd0;
    add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
    add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0);
    add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h14, 32'h0F0F1234);
    add(1, HTRANS_SEQ,    0, HSIZE_WORD, 32'h14, 32'h0);
    add(1, HTRANS_SEQ,    0, HSIZE_WORD, 32'h10, 32'h0);
    run_bus();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (obs.size() == 0) begin miscompares++; $display("FAIL b2b_missing got none want response"); end
      else begin
        o = obs.pop_front();
        if (o.waits !== e.waits) begin miscompares++; $display("FAIL b2b_waits got %0d want %0d", o.waits, e.waits); end
        vectors++;
        if (o.resp !== e.resp) begin miscompares++; $display("FAIL b2b_resp got %b want %b", o.resp, e.resp); end
        vectors++;
        if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL b2b_rdata got %h want %h", o.rdata, e.rdata); end
      end
    end
    obs.delete();
  endtask

  task automatic test_byte_lanes();
    rec_t e, o;
    cur = 2'd0;
    add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20, 32'h00000000);
    add(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h21, 32'h5555AA55);
    add(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h22, 32'h12349999);
    add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0);
    add(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h23, 32'h77000000);
    add(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h20, 32'hFFFFBEEF);
    add(1, HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'h22, 32'h0);
    run_bus();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (obs.size() == 0) begin miscompares++; $display("FAIL lanes_missing got none want response"); end
      else begin
        o = obs.pop_front();
        if (o.waits !== e.waits) begin miscompares++; $display("FAIL lanes_waits got %0d want %0d", o.waits, e.waits); end
        vectors++;
        if (o.resp !== e.resp) begin miscompares++; $display("FAIL lanes_resp got %b want %b", o.resp, e.resp); end
        vectors++;
        if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL lanes_rdata got %h want %h", o.rdata, e.rdata); end
      end
    end
    obs.delete();
  endtask

  task automatic test_wait_states();
    rec_t e, o;
    cur = 2'd1;
    add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h08, 32'hA5A5C3C3);
    add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h08, 32'h0);
    add(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h0A, 32'h6789FFFF);
    add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h08, 32'h0);
    run_bus();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (obs.size() == 0) begin miscompares++; $display("FAIL wait_missing got none want response"); end
      else begin
        o = obs.pop_front();
        if (o.waits !== e.waits) begin miscompares++; $display("FAIL wait_count got %0d want %0d", o.waits, e.waits); end
        vectors++;
        if (o.resp !== e.resp) begin miscompares++; $display("FAIL wait_resp got %b want %b", o.resp, e.resp); end
        vectors++;
        if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL wait_rdata got %h want %h", o.rdata, e.rdata); end
      end
    end
    obs.delete();
  endtask

  task automatic test_illegal();
    rec_t e, o;
    for (int c = 0; c < 2; c++) begin
      cur = 2'(c);
      add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h0, 32'hCAFEF00D);
      add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h4, 32'h01234567);
      add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h2, 32'hFFFFFFFF);
      add(1, HTRANS_NONSEQ, 1, 3'd3,       32'h4, 32'hEEEEEEEE);
      add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'(DEPTH * 4), 32'hBBBBBBBB);
      add(1, HTRANS_NONSEQ, 0, HSIZE_HALF, 32'h1, 32'h0);
      add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0, 32'h0);
      add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h4, 32'h0);
      run_bus();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (obs.size() == 0) begin miscompares++; $display("FAIL illegal_missing dut%0d got none want response", c); end
        else begin
          o = obs.pop_front();
          if (o.waits !== e.waits) begin miscompares++; $display("FAIL illegal_waits dut%0d got %0d want %0d", c, o.waits, e.waits); end
          vectors++;
          if (o.resp !== e.resp) begin miscompares++; $display("FAIL illegal_resp dut%0d got %b want %b", c, o.resp, e.resp); end
          vectors++;
          if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL illegal_rdata dut%0d got %h want %h", c, o.rdata, e.rdata); end
        end
      end
      obs.delete();
    end
  endtask

  task automatic test_idle_busy_hsel();
    rec_t e, o;
    cur = 2'd0;
    add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h40, 32'h0BADCAFE);
    add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h40, 32'h0);
    add(1, HTRANS_IDLE,   1, HSIZE_WORD, 32'h40, 32'h11111111);
    add(1, HTRANS_BUSY,   1, HSIZE_WORD, 32'h40, 32'h22222222);
    add(0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h40, 32'h33333333);
    add(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h40, 32'h0);
    add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h40, 32'h0);
    run_bus();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (obs.size() == 0) begin miscompares++; $display("FAIL idle_missing got none want response"); end
      else begin
        o = obs.pop_front();
        if (o.waits !== e.waits) begin miscompares++; $display("FAIL idle_waits got %0d want %0d", o.waits, e.waits); end
        vectors++;
        if (o.resp !== e.resp) begin miscompares++; $display("FAIL idle_resp got %b want %b", o.resp, e.resp); end
        vectors++;
        if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL idle_rdata got %h want %h", o.rdata, e.rdata); end
      end
    end
    obs.delete();
  endtask

  task automatic test_reset_mid();
    rec_t e, o;
    cur = 2'd2;
    add(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h30, 32'h11111111);
    add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h30, 32'h0);
    run_bus();
    // Start a write, then pull reset while it is still waiting.
    b_sel = 1'b1; b_trans = HTRANS_NONSEQ; b_write = 1'b1; b_size = HSIZE_WORD; b_addr = 32'h30;
    @(posedge HCLK); #1;
    b_sel = 1'b0; b_trans = HTRANS_IDLE; b_wdata = 32'h22222222;
    @(negedge HCLK);
    vectors++;
    if (o_rdy !== 1'b0) begin miscompares++; $display("FAIL midreset_in_wait got %b want 0", o_rdy); end
    #2 HRESETn = 1'b0;
    #1;
    vectors++;
    if (o_rdy !== 1'b1) begin miscompares++; $display("FAIL midreset_hreadyout got %b want 1", o_rdy); end
    vectors++;
    if (o_resp !== 1'b0) begin miscompares++; $display("FAIL midreset_hresp got %b want 0", o_resp); end
    vectors++;
    if (o_rdata !== 32'h0) begin miscompares++; $display("FAIL midreset_hrdata got %h want 0", o_rdata); end
    for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
    @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    drive_idle();
    add(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h30, 32'h0);
    run_bus();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (obs.size() == 0) begin miscompares++; $display("FAIL midreset_missing got none want response"); end
      else begin
        o = obs.pop_front();
        if (o.waits !== e.waits) begin miscompares++; $display("FAIL midreset_waits got %0d want %0d", o.waits, e.waits); end
        vectors++;
        if (o.resp !== e.resp) begin miscompares++; $display("FAIL midreset_resp got %b want %b", o.resp, e.resp); end
        vectors++;
        if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL midreset_rdata got %h want %h", o.rdata, e.rdata); end
      end
    end
    obs.delete();
  endtask

  initial begin
    cur = 2'd0;
    for (int i = 0; i < 3; i++) begin
      last_rd[i] = 32'h0;
      for (int j = 0; j < DEPTH; j++) mdl[i][j] = 32'h0;
    end
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_wait_states();
    test_illegal();
    test_idle_busy_hsel();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

AHB-Lite slave that terminates the transfers issued by the team's AHB-Lite master: a word-organised on-chip SRAM with a programmable number of wait states, byte/halfword/word accesses and a two-cycle ERROR response for illegal transfers. It sits directly downstream of the master, behind the address decoder (HSEL) and in front of the read-data/response multiplexer.

## Interface
- DEPTH, 256: number of 32-bit words; a power of two, at least 4.
- WAIT_STATES, 0: wait cycles inserted in every OKAY data phase; range 0..15.
- HCLK  in  1  bus clock; all logic on the rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  byte address.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word; 3..7 are illegal.
- HTRANS  in  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready (mux output), used to qualify the address phase.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data, registered.

## Operation
- **Address-phase capture.** When HSEL && HREADY && HTRANS[1] are all high at a rising edge, latch HADDR, HWRITE and HSIZE, plus a legality flag, into data-phase registers.
- **Idle transfers.** Transfers with HTRANS IDLE or BUSY, or with HSEL low, get a zero-wait OKAY and have no side effects.
- **Illegal transfers.** Any of the following is illegal:
  - HSIZE > 2;
  - HSIZE = 1 with HADDR[0] = 1;
  - HSIZE = 2 with HADDR[1:0] != 0;
  - HADDR[31:2] >= DEPTH.
- **Byte lanes.** Little-endian.
  - Byte access: lane HADDR[1:0].
  - Halfword access: lanes {HADDR[1],0} and {HADDR[1],1}.
  - Word access: all four lanes.
- **Writes.** Only the enabled lanes of HWDATA are written, at the final edge of an OKAY data phase. An errored write never modifies memory.
- **Reads.** HRDATA returns the full 32-bit word; the master selects the lane.
- **FSM states:**
  - IDLE: no data phase pending. HREADYOUT = 1, HRESP = 0.
  - WAIT: counter counts WAIT_STATES down to 0. HREADYOUT = 0, HRESP = 0.
  - DONE: final OKAY cycle. HREADYOUT = 1, HRESP = 0.
  - ERR1: HREADYOUT = 0, HRESP = 1.
  - ERR2: HREADYOUT = 1, HRESP = 1.
- **FSM transitions.**
  - On capture of a legal transfer: go to WAIT if WAIT_STATES > 0, otherwise DONE.
  - On capture of an illegal transfer: go to ERR1.
  - ERR1 always goes to ERR2.
  - From WAIT, when the counter reaches 0: go to DONE.
  - Leaving DONE or ERR2: go to the state implied by the new capture if one occurs on that edge, otherwise to IDLE.
- **Back-to-back transfers.** A new capture in the DONE/ERR2 cycle is legal, so back-to-back transfers sustain one per cycle when WAIT_STATES = 0.
- **Read-after-write forwarding.** A read captured on the same edge that commits a write to the same word must return the merged data: new lanes from HWDATA, old lanes from memory.
- **Master abort after ERROR.** If the master presents IDLE during ERR2, the slave returns to IDLE.
- **Reset mid-operation.**
  - FSM goes to IDLE immediately and the counter clears.
  - Any write that has not been committed is dropped.
  - Memory contents are not reset.

## Timing
- **Reset values:** HREADYOUT = 1, HRESP = 0, HRDATA = 0, FSM = IDLE, wait counter = 0, data-phase registers = 0.
- **OKAY latency:**
  - The address phase is cycle N.
  - The data phase is cycles N+1 .. N+1+WAIT_STATES.
  - HREADYOUT is high only in the last of these cycles.
- **Read data:** HRDATA is registered on the edge that enters DONE, so it is valid for the whole DONE cycle. HRDATA holds its value otherwise.
- **ERROR response:** always exactly two cycles (ERR1, then ERR2), independent of WAIT_STATES.
- **Write commit:** memory is written at the edge ending DONE, using the HWDATA sampled at that edge.
- **Wait-state hold:** during WAIT and ERR1, HREADY is low, so no new capture occurs and the master holds the next address.

## Structure
- **Shared package `ahb_lite_pkg`** holds:
  - HTRANS codes, HRESP codes and HSIZE codes;
  - the FSM state enum;
  - a lane-enable function (size, addr[1:0]) -> 4-bit mask.
- **Sub-module `ahb_lite_sram_array`:** DEPTH x 32 memory with a 4-bit write-byte-enable and synchronous read. It contains the forwarding merge. The slave top holds the FSM, capture registers and legality check.

## Test plan
- **Reset:** assert HRESETn = 0 mid-WAIT with WAIT_STATES = 3 -> outputs are immediately HREADYOUT = 1, HRESP = 0, HRDATA = 0; the pending write is absent on read-back.
- **Back-to-back, zero wait:** with WAIT_STATES = 0, write word 0xDEADBEEF @0x10, then read @0x10 on the next cycle -> HRDATA = 0xDEADBEEF (forwarded) with no stall.
- **Byte lanes:** write byte 0xAA @0x21 and halfword 0x1234 @0x22 over word 0x00000000 -> word read @0x20 returns 0x1234AA00.
- **Wait states:** with WAIT_STATES = 2, read -> HREADYOUT low for exactly 2 cycles, then high with valid data.
- **Illegal transfers:** word @0x02, HSIZE = 3, and address DEPTH*4 -> each gives HRESP = 1 for 2 cycles with HREADYOUT 0 then 1; memory is unchanged.
- **IDLE, BUSY and HSEL low:** each -> HREADYOUT = 1, HRESP = 0, no memory change, HRDATA unchanged.
